// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: prescaled digit scan with an anode-off
// guard cycle, per-digit blank/dp, and frame-synchronous (tear-free) value update.
module seven_seg_scan_driver #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned DIV        = 50000,
  parameter bit          ACTIVE_LOW = 1'b1,
  localparam int unsigned IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int unsigned CW        = $clog2(DIV)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*DIGITS-1:0] value,
  input  logic              load,
  input  logic [DIGITS-1:0] blank,
  input  logic [DIGITS-1:0] dp,
  input  logic              en,
  output logic [6:0]        seg,
  output logic              dp_out,
  output logic [DIGITS-1:0] an,
  output logic [IW-1:0]     digit_idx,
  output logic              frame_done
);

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h7E;
      4'h1: decode = 7'h30;
      4'h2: decode = 7'h6D;
      4'h3: decode = 7'h79;
      4'h4: decode = 7'h33;
      4'h5: decode = 7'h5B;
      4'h6: decode = 7'h5F;
      4'h7: decode = 7'h70;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h7B;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h1F;
      4'hC: decode = 7'h4E;
      4'hD: decode = 7'h3D;
      4'hE: decode = 7'h4F;
      default: decode = 7'h47;
    endcase
  endfunction

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                guard_q, guard_d;
  logic                frame_done_q, frame_done_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] pending_q, pending_d;
  logic                pend_v_q, pend_v_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic              adv, last, wrap, active, blk, dpr;
  logic [3:0]        nib;
  logic [DIGITS-1:0] onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      guard_q      <= 1'b0;
      frame_done_q <= 1'b0;
      shadow_q     <= '0;
      pending_q    <= '0;
      pend_v_q     <= 1'b0;
      seg_q        <= {7{ACTIVE_LOW}};
      dp_q         <= ACTIVE_LOW;
      an_q         <= {DIGITS{ACTIVE_LOW}};
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      guard_q      <= guard_d;
      frame_done_q <= frame_done_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_v_q     <= pend_v_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  // Prescaler, digit advance and frame-synchronous buffer swap
  always_comb begin
    adv          = en && (cnt_q == CW'(DIV - 1));
    last         = (idx_q == IW'(DIGITS - 1));
    wrap         = adv && last;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    pend_v_d     = pend_v_q;
    guard_d      = adv;
    frame_done_d = wrap;
    if (en) begin
      if (adv) begin
        cnt_d = '0;
        idx_d = last ? '0 : idx_q + IW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (wrap && load) begin
      shadow_d = value;
      pend_v_d = 1'b0;
    end else if (wrap && pend_v_q) begin
      shadow_d = pending_q;
      pend_v_d = 1'b0;
    end else if (load) begin
      pending_d = value;
      pend_v_d  = 1'b1;
    end
  end

  // Output stage: select current digit, apply blanking, then pin polarity
  always_comb begin
    nib    = 4'h0;
    blk    = 1'b0;
    dpr    = 1'b0;
    onehot = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib       = shadow_q[4*i +: 4];
        blk       = blank[i];
        dpr       = dp[i];
        onehot[i] = 1'b1;
      end
    end
    active = en && !guard_q;
    an_d   = (active ? onehot : '0) ^ {DIGITS{ACTIVE_LOW}};
    seg_d  = ((active && !blk) ? decode(nib) : 7'h00) ^ {7{ACTIVE_LOW}};
    dp_d   = (dpr && !blk && active) ^ ACTIVE_LOW;
  end

  assign seg        = seg_q;
  assign dp_out     = dp_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;

endmodule
